// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, drives instruction memory and holds the
// IF/ID pipeline register, with stall (freeze) and branch redirect/flush.
module fetch_stage #(
  parameter int                  WORD_LEN = 32,
  parameter logic [WORD_LEN-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                freeze,
  input  logic                br_taken,
  input  logic [WORD_LEN-1:0] br_base_pc,
  input  logic [WORD_LEN-1:0] br_offset,
  output logic [WORD_LEN-1:0] inst_addr,
  input  logic [WORD_LEN-1:0] inst_in,
  output logic [WORD_LEN-1:0] pc_out,
  output logic [WORD_LEN-1:0] instruction_out,
  output logic                valid_out,
  output logic [WORD_LEN-1:0] fetch_count,
  output logic                halted,
  output logic                fsm_state
);

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_REDIRECT = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [WORD_LEN-1:0] pc_q, pc_d;
  logic [WORD_LEN-1:0] pc_out_q, pc_out_d;
  logic [WORD_LEN-1:0] inst_q, inst_d;
  logic                valid_q, valid_d;
  logic [WORD_LEN-1:0] count_q, count_d;
  logic                halted_q, halted_d;
  logic [WORD_LEN-1:0] br_target;
  logic [WORD_LEN-1:0] pc_plus4;

  // Redirect wins over freeze: the stalled instruction is on the wrong path anyway.
  always_comb begin
    br_target = br_base_pc + (br_offset << 2);
    pc_plus4  = pc_q + WORD_LEN'(4);
    state_d   = ST_RUN;
    pc_d      = pc_q;
    pc_out_d  = pc_out_q;
    inst_d    = inst_q;
    valid_d   = valid_q;
    count_d   = count_q;
    halted_d  = halted_q;
    if (br_taken) begin
      state_d  = ST_REDIRECT;
      pc_d     = br_target;
      pc_out_d = '0;
      inst_d   = '0;
      valid_d  = 1'b0;
      if (br_target == br_base_pc - WORD_LEN'(4)) begin
        halted_d = 1'b1;
      end
    end else if (!freeze) begin
      pc_d     = pc_plus4;
      pc_out_d = pc_plus4;
      inst_d   = inst_in;
      valid_d  = 1'b1;
      if (count_q != '1) begin
        count_d = count_q + WORD_LEN'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_RUN;
      pc_q     <= RESET_PC;
      pc_out_q <= '0;
      inst_q   <= '0;
      valid_q  <= 1'b0;
      count_q  <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      pc_out_q <= pc_out_d;
      inst_q   <= inst_d;
      valid_q  <= valid_d;
      count_q  <= count_d;
      halted_q <= halted_d;
    end
  end

  assign inst_addr       = pc_q;
  assign pc_out          = pc_out_q;
  assign instruction_out = inst_q;
  assign valid_out       = valid_q;
  assign fetch_count     = count_q;
  assign halted          = halted_q;
  assign fsm_state       = (state_q == ST_REDIRECT);

endmodule

// File: tb/tb_fetch_stage.sv
// Directed vector bench for fetch_stage, plus a narrow instance to reach
// fetch_count saturation.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst, freeze, br_taken;
  logic [31:0] br_base_pc, br_offset;
  logic [31:0] inst_addr, inst_in, pc_out, instruction_out, fetch_count;
  logic        valid_out, halted, fsm_state;

  logic        s_rst;
  logic        s_zero = 1'b0;
  logic [3:0]  s_zero4 = 4'h0;
  logic [3:0]  s_addr, s_pc_out, s_inst, s_count;
  logic        s_valid, s_halted, s_state;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  // Instruction memory model: each word is its address tagged with a pattern.
  assign inst_in = inst_addr ^ 32'hDEAD_0000;

  fetch_stage #(.WORD_LEN(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .br_taken(br_taken),
    .br_base_pc(br_base_pc), .br_offset(br_offset), .inst_addr(inst_addr),
    .inst_in(inst_in), .pc_out(pc_out), .instruction_out(instruction_out),
    .valid_out(valid_out), .fetch_count(fetch_count), .halted(halted),
    .fsm_state(fsm_state)
  );

  fetch_stage #(.WORD_LEN(4), .RESET_PC(4'h0)) dut_small (
    .clk(clk), .rst(s_rst), .freeze(s_zero), .br_taken(s_zero),
    .br_base_pc(s_zero4), .br_offset(s_zero4), .inst_addr(s_addr),
    .inst_in(s_zero4), .pc_out(s_pc_out), .instruction_out(s_inst),
    .valid_out(s_valid), .fetch_count(s_count), .halted(s_halted),
    .fsm_state(s_state)
  );

  typedef struct {
    logic        rst, frz, br;
    logic [31:0] base, off;
    logic [31:0] e_addr, e_pc, e_ins;
    logic        e_val;
    logic [31:0] e_cnt;
    logic        e_halt, e_st;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s vec %0d: got %h want %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic f, input logic b,
                       input logic [31:0] base, input logic [31:0] off);
    @(negedge clk);
    rst = r; freeze = f; br_taken = b; br_base_pc = base; br_offset = off;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; freeze = 1'b0; br_taken = 1'b0;
    br_base_pc = '0; br_offset = '0; s_rst = 1'b1;

    //                rst frz br  base          off           addr          pc_out        instr         val cnt halt st
    vecs.push_back('{1'b1,1'b0,1'b0,32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        1'b0,32'd0,1'b0,1'b0});
    vecs.push_back('{1'b1,1'b0,1'b0,32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        1'b0,32'd0,1'b0,1'b0});
    vecs.push_back('{1'b0,1'b0,1'b0,32'h0,        32'h0,        32'h4,        32'h4,        32'hDEAD0000, 1'b1,32'd1,1'b0,1'b0});
    vecs.push_back('{1'b0,1'b0,1'b0,32'h0,        32'h0,        32'h8,        32'h8,        32'hDEAD0004, 1'b1,32'd2,1'b0,1'b0});
    vecs.push_back('{1'b0,1'b1,1'b0,32'h0,        32'h0,        32'h8,        32'h8,        32'hDEAD0004, 1'b1,32'd2,1'b0,1'b0});
    vecs.push_back('{1'b0,1'b1,1'b0,32'h0,        32'h0,        32'h8,        32'h8,        32'hDEAD0004, 1'b1,32'd2,1'b0,1'b0});
    vecs.push_back('{1'b0,1'b0,1'b0,32'h0,        32'h0,        32'hC,        32'hC,        32'hDEAD0008, 1'b1,32'd3,1'b0,1'b0});
    vecs.push_back('{1'b0,1'b0,1'b0,32'h0,        32'h0,        32'h10,       32'h10,       32'hDEAD000C, 1'b1,32'd4,1'b0,1'b0});
    vecs.push_back('{1'b0,1'b0,1'b1,32'hA0,       32'h2,        32'hA8,       32'h0,        32'h0,        1'b0,32'd4,1'b0,1'b1});
    vecs.push_back('{1'b0,1'b0,1'b0,32'h0,        32'h0,        32'hAC,       32'hAC,       32'hDEAD00A8, 1'b1,32'd5,1'b0,1'b0});
    vecs.push_back('{1'b0,1'b0,1'b1,32'hB0,       32'hFFFFFFF1, 32'h74,       32'h0,        32'h0,        1'b0,32'd5,1'b0,1'b1});
    // back-to-back branch while in redirect, with freeze also asserted
    vecs.push_back('{1'b0,1'b1,1'b1,32'h100,      32'h4,        32'h110,      32'h0,        32'h0,        1'b0,32'd5,1'b0,1'b1});
    vecs.push_back('{1'b0,1'b0,1'b0,32'h0,        32'h0,        32'h114,      32'h114,      32'hDEAD0110, 1'b1,32'd6,1'b0,1'b0});
    vecs.push_back('{1'b1,1'b0,1'b1,32'hA0,       32'h2,        32'h0,        32'h0,        32'h0,        1'b0,32'd0,1'b0,1'b0});
    vecs.push_back('{1'b0,1'b0,1'b0,32'h0,        32'h0,        32'h4,        32'h4,        32'hDEAD0000, 1'b1,32'd1,1'b0,1'b0});
    vecs.push_back('{1'b0,1'b0,1'b1,32'hE8,       32'hFFFFFFFF, 32'hE4,       32'h0,        32'h0,        1'b0,32'd1,1'b1,1'b1});
    vecs.push_back('{1'b0,1'b0,1'b0,32'h0,        32'h0,        32'hE8,       32'hE8,       32'hDEAD00E4, 1'b1,32'd2,1'b1,1'b0});
    vecs.push_back('{1'b0,1'b1,1'b0,32'h0,        32'h0,        32'hE8,       32'hE8,       32'hDEAD00E4, 1'b1,32'd2,1'b1,1'b0});
    vecs.push_back('{1'b0,1'b0,1'b1,32'h0,        32'hFFFFFFFF, 32'hFFFFFFFC, 32'h0,        32'h0,        1'b0,32'd2,1'b1,1'b1});
    vecs.push_back('{1'b0,1'b0,1'b0,32'h0,        32'h0,        32'h0,        32'h0,        32'h2152FFFC, 1'b1,32'd3,1'b1,1'b0});
    vecs.push_back('{1'b1,1'b0,1'b0,32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        1'b0,32'd0,1'b0,1'b0});

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].frz, vecs[i].br, vecs[i].base, vecs[i].off);
      check("inst_addr",       i, inst_addr,              vecs[i].e_addr);
      check("pc_out",          i, pc_out,                 vecs[i].e_pc);
      check("instruction_out", i, instruction_out,        vecs[i].e_ins);
      check("valid_out",       i, {31'b0, valid_out},     {31'b0, vecs[i].e_val});
      check("fetch_count",     i, fetch_count,            vecs[i].e_cnt);
      check("halted",          i, {31'b0, halted},        {31'b0, vecs[i].e_halt});
      check("fsm_state",       i, {31'b0, fsm_state},     {31'b0, vecs[i].e_st});
    end

    // Narrow instance: fetch_count must stop at all-ones.
    @(negedge clk); s_rst = 1'b1;
    @(posedge clk); #1;
    check("small_reset_count", 0, {28'b0, s_count}, 32'd0);
    @(negedge clk); s_rst = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      exp_q.push_back((c > 15) ? 32'd15 : 32'(c));
      @(posedge clk); #1;
      check("small_sat_count", c, {28'b0, s_count}, exp_q.pop_front());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
